// File: rtl/dma_bus_arbiter_if.sv
// dma_bus_arbiter_if: request/grant bundle between the DMA channels, the
// Dcache status and the bus arbiter.
//   br          per-channel bus request (level)
//   mem_idle    Dcache has no memory access in flight
//   xfer_word   one-cycle strobe, granted channel moved one bus word
//   bg          one-hot bus grant
//   cpu_hold    freezes the Dcache memory side
//   grant_ch    index of current/last winner
//   word_cnt    words moved in the current grant
//   last_cnt    word count captured when the last grant ended
//   end_irq     per-channel pulse, channel released the bus itself
//   preempt_irq per-channel pulse, grant revoked at MAX_BURST
// Modports: slave = arbiter side, master = requester/environment side.
interface dma_bus_arbiter_if #(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned MAX_BURST = 16
);
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] br;
   logic              mem_idle;
   logic              xfer_word;
   logic [NUM_CH-1:0] bg;
   logic              cpu_hold;
   logic [CH_W-1:0]   grant_ch;
   logic [CNT_W-1:0]  word_cnt;
   logic [CNT_W-1:0]  last_cnt;
   logic [NUM_CH-1:0] end_irq;
   logic [NUM_CH-1:0] preempt_irq;

   modport slave (
      input  br, mem_idle, xfer_word,
      output bg, cpu_hold, grant_ch, word_cnt, last_cnt, end_irq, preempt_irq
   );

   modport master (
      output br, mem_idle, xfer_word,
      input  bg, cpu_hold, grant_ch, word_cnt, last_cnt, end_irq, preempt_irq
   );
endinterface

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: round-robin bus arbiter between the CPU data-memory port
// and NUM_CH DMA channels. A winner first waits for the Dcache to go idle
// (cpu_hold already asserted), then owns the bus until it drops br or moves
// MAX_BURST words, followed by a one-cycle turnaround.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    dma_bus_arbiter_if.slave (br/mem_idle/xfer_word in; bg, cpu_hold,
//          grant_ch, word_cnt, last_cnt, end_irq, preempt_irq out, all registered)
module dma_bus_arbiter #(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic             clk,
   input  logic             reset,
   dma_bus_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
   localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(MAX_BURST);
   localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

   typedef enum logic [1:0] {IDLE, WAIT_IDLE, GRANT, RELEASE} state_t;

   state_t            state_q, state_d;
   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic [CH_W-1:0]   grant_ch_q, grant_ch_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]  last_cnt_q, last_cnt_d;
   logic [NUM_CH-1:0] bg_q, bg_d;
   logic [NUM_CH-1:0] end_irq_q, end_irq_d;
   logic [NUM_CH-1:0] preempt_irq_q, preempt_irq_d;
   logic              cpu_hold_q, cpu_hold_d;

   logic              req_any_c;
   logic [CH_W-1:0]   winner_c;
   logic [NUM_CH-1:0] onehot_c;
   logic              owner_req_c;
   logic [SUM_W-1:0]  sum_c;
   logic [CNT_W-1:0]  cnt_next_c;

   // Round-robin pick: first requesting channel at or above ptr, wrapping.
   always_comb begin
      int unsigned idx;
      req_any_c = 1'b0;
      winner_c  = '0;
      idx       = 0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!req_any_c && bus.br[CH_W'(idx)]) begin
            req_any_c = 1'b1;
            winner_c  = CH_W'(idx);
         end
      end
   end

   // Owner's request, grant vector and saturating word count including this cycle's strobe.
   always_comb begin
      onehot_c    = NUM_CH'(1) << grant_ch_q;
      owner_req_c = bus.br[grant_ch_q];
      sum_c       = {1'b0, word_cnt_q} + SUM_W'(bus.xfer_word);
      cnt_next_c  = (sum_c > MAX_SUM) ? MAX_CNT : sum_c[CNT_W-1:0];
   end

   // Next state and next registered outputs.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_ch_d    = grant_ch_q;
      word_cnt_d    = word_cnt_q;
      last_cnt_d    = last_cnt_q;
      bg_d          = '0;
      cpu_hold_d    = 1'b1;
      end_irq_d     = '0;
      preempt_irq_d = '0;

      case (state_q)
         IDLE: begin
            cpu_hold_d = 1'b0;
            if (req_any_c) begin
               grant_ch_d = winner_c;
               word_cnt_d = '0;
               cpu_hold_d = 1'b1;
               state_d    = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            // Winner is frozen here; only its own withdrawal cancels the grant.
            if (!owner_req_c) begin
               cpu_hold_d = 1'b0;
               state_d    = IDLE;
            end else if (bus.mem_idle) begin
               bg_d    = onehot_c;
               state_d = GRANT;
            end
         end
         GRANT: begin
            word_cnt_d = cnt_next_c;
            // A br drop wins over reaching MAX_BURST in the same cycle.
            if (!owner_req_c) begin
               end_irq_d[grant_ch_q] = 1'b1;
               last_cnt_d            = cnt_next_c;
               state_d               = RELEASE;
            end else if (cnt_next_c == MAX_CNT) begin
               preempt_irq_d[grant_ch_q] = 1'b1;
               last_cnt_d                = cnt_next_c;
               state_d                   = RELEASE;
            end else begin
               bg_d = onehot_c;
            end
         end
         RELEASE: begin
            ptr_d      = (grant_ch_q == LAST_CH) ? '0 : grant_ch_q + CH_W'(1);
            cpu_hold_d = 1'b0;
            state_d    = IDLE;
         end
         default: begin
            cpu_hold_d = 1'b0;
            state_d    = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         grant_ch_q    <= '0;
         word_cnt_q    <= '0;
         last_cnt_q    <= '0;
         bg_q          <= '0;
         cpu_hold_q    <= 1'b0;
         end_irq_q     <= '0;
         preempt_irq_q <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_ch_q    <= grant_ch_d;
         word_cnt_q    <= word_cnt_d;
         last_cnt_q    <= last_cnt_d;
         bg_q          <= bg_d;
         cpu_hold_q    <= cpu_hold_d;
         end_irq_q     <= end_irq_d;
         preempt_irq_q <= preempt_irq_d;
      end
   end

   assign bus.bg          = bg_q;
   assign bus.cpu_hold    = cpu_hold_q;
   assign bus.grant_ch    = grant_ch_q;
   assign bus.word_cnt    = word_cnt_q;
   assign bus.last_cnt    = last_cnt_q;
   assign bus.end_irq     = end_irq_q;
   assign bus.preempt_irq = preempt_irq_q;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: two instances (MAX_BURST 16 and 4) share one
// stimulus stream; directed scenarios plus a randomized run against a
// transaction-level reference model.
module tb_dma_bus_arbiter;
   localparam int NCH  = 2;
   localparam int MB_L = 16;
   localparam int MB_S = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] br;
   logic       mem_idle;
   logic       xfer_word;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   dma_bus_arbiter_if #(.NUM_CH(NCH), .MAX_BURST(MB_L)) if_l ();
   dma_bus_arbiter_if #(.NUM_CH(NCH), .MAX_BURST(MB_S)) if_s ();

   assign if_l.br = br;  assign if_l.mem_idle = mem_idle;  assign if_l.xfer_word = xfer_word;
   assign if_s.br = br;  assign if_s.mem_idle = mem_idle;  assign if_s.xfer_word = xfer_word;

   dma_bus_arbiter #(.NUM_CH(NCH), .MAX_BURST(MB_L)) dut_l (.clk(clk), .reset(reset), .bus(if_l.slave));
   dma_bus_arbiter #(.NUM_CH(NCH), .MAX_BURST(MB_S)) dut_s (.clk(clk), .reset(reset), .bus(if_s.slave));

   // Reference model: who owns the bus, whether it is on the bus yet, and a
   // one-cycle cool-down after every grant.
   typedef struct {
      int       owner;   // -1 when nobody has won
      bit       on_bus;
      bit       cool;
      int       ptr;
      int       gch;
      int       cnt;
      int       last;
      bit [1:0] eirq;
      bit [1:0] pirq;
      bit       hold;
   } mdl_t;

   mdl_t m [2];

   function automatic mdl_t model_next(mdl_t s, int mb, logic rst, logic [1:0] b, logic mi, logic xw);
      mdl_t n;
      int   c;
      int   w;
      n      = s;
      n.eirq = 2'b00;
      n.pirq = 2'b00;
      if (rst) begin
         n.owner = -1; n.on_bus = 0; n.cool = 0; n.ptr = 0; n.gch = 0;
         n.cnt = 0; n.last = 0; n.hold = 0;
      end else if (s.cool) begin
         n.cool = 0; n.owner = -1; n.hold = 0;
         n.ptr  = (s.gch + 1) % NCH;
      end else if (s.owner < 0) begin
         for (int i = 0; i < NCH; i++) begin
            c = (s.ptr + i) % NCH;
            if (n.owner < 0 && b[c]) begin
               n.owner = c; n.gch = c; n.cnt = 0; n.hold = 1;
            end
         end
      end else if (!s.on_bus) begin
         if (!b[s.owner]) begin
            n.owner = -1; n.hold = 0;
         end else if (mi) begin
            n.on_bus = 1;
         end
      end else begin
         w = s.cnt + (xw ? 1 : 0);
         if (w > mb) w = mb;
         n.cnt = w;
         if (!b[s.owner]) begin
            n.eirq[s.owner] = 1'b1; n.last = w; n.on_bus = 0; n.cool = 1;
         end else if (w == mb) begin
            n.pirq[s.owner] = 1'b1; n.last = w; n.on_bus = 0; n.cool = 1;
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m[0] <= model_next(m[0], MB_L, reset, br, mem_idle, xfer_word);
      m[1] <= model_next(m[1], MB_S, reset, br, mem_idle, xfer_word);
   end

   function automatic logic [17:0] exp_vec(int k);
      mdl_t       s;
      logic [1:0] bgv;
      s   = m[k];
      bgv = s.on_bus ? (2'b01 << s.gch) : 2'b00;
      return {bgv, s.hold, 1'(s.gch), 5'(s.cnt), 5'(s.last), s.eirq, s.pirq};
   endfunction

   function automatic logic [17:0] dut_vec(int k);
      if (k == 0)
         return {if_l.bg, if_l.cpu_hold, if_l.grant_ch, 5'(if_l.word_cnt), 5'(if_l.last_cnt),
                 if_l.end_irq, if_l.preempt_irq};
      return {if_s.bg, if_s.cpu_hold, if_s.grant_ch, 5'(if_s.word_cnt), 5'(if_s.last_cnt),
              if_s.end_irq, if_s.preempt_irq};
   endfunction

   task automatic tick(input logic [1:0] b, input logic mi, input logic xw);
      br = b; mem_idle = mi; xfer_word = xw;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2'b00, 1'b1, 1'b0);
      tick(2'b00, 1'b1, 1'b0);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick(2'b11, 1'b1, 1'b0);
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (dut_vec(k) !== 18'd0) begin
               miscompares++;
               $display("FAIL reset_defaults dut%0d got %h want 0", k, dut_vec(k));
            end
         end
      end
      reset = 1'b0;
      tick(2'b11, 1'b1, 1'b0);
      vectors++;
      if (if_l.cpu_hold !== 1'b1 || if_l.bg !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_wait hold=%b bg=%b want hold=1 bg=00", if_l.cpu_hold, if_l.bg);
      end
      tick(2'b11, 1'b1, 1'b0);
      vectors++;
      if (if_l.bg !== 2'b01 || if_s.bg !== 2'b01 || if_l.grant_ch !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_first_grant bg=%b/%b ch=%b want 01 ch0", if_l.bg, if_s.bg, if_l.grant_ch);
      end
   endtask

   task automatic test_single_transfer();
      do_reset();
      tick(2'b10, 1'b1, 1'b0);
      tick(2'b10, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick(2'b10, 1'b1, 1'b1);
         vectors++;
         if (if_l.bg !== 2'b10 || if_l.word_cnt !== 5'(i + 1)) begin
            miscompares++;
            $display("FAIL single_burst bg=%b cnt=%0d want 10 cnt=%0d", if_l.bg, if_l.word_cnt, i + 1);
         end
      end
      tick(2'b00, 1'b1, 1'b0);
      vectors++;
      if (if_l.end_irq !== 2'b10 || if_l.last_cnt !== 5'd5 || if_l.bg !== 2'b00 || if_l.cpu_hold !== 1'b1) begin
         miscompares++;
         $display("FAIL single_end irq=%b last=%0d bg=%b hold=%b want 10 5 00 1",
                  if_l.end_irq, if_l.last_cnt, if_l.bg, if_l.cpu_hold);
      end
      tick(2'b00, 1'b1, 1'b0);
      vectors++;
      if (if_l.cpu_hold !== 1'b0 || if_l.end_irq !== 2'b00) begin
         miscompares++;
         $display("FAIL single_idle hold=%b irq=%b want 0 00", if_l.cpu_hold, if_l.end_irq);
      end
   endtask

   task automatic test_wait_cache();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         tick(2'b01, 1'b0, 1'b0);
         vectors++;
         if (if_l.cpu_hold !== 1'b1 || if_l.bg !== 2'b00) begin
            miscompares++;
            $display("FAIL wait_cache hold=%b bg=%b want 1 00", if_l.cpu_hold, if_l.bg);
         end
      end
      tick(2'b01, 1'b1, 1'b0);
      vectors++;
      if (if_l.bg !== 2'b01) begin
         miscompares++;
         $display("FAIL wait_cache_grant bg=%b want 01", if_l.bg);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] want;
      logic [1:0] drop;
      int         waited;
      int         ch;
      do_reset();
      for (int g = 0; g < 3; g++) begin
         waited = 0;
         while (if_l.bg === 2'b00 && waited < 8) begin
            tick(2'b11, 1'b1, 1'b0);
            waited++;
         end
         ch   = (g == 1) ? 1 : 0;
         want = 2'b01 << ch;
         vectors++;
         if (if_l.bg !== want || if_s.bg !== want) begin
            miscompares++;
            $display("FAIL rr_grant%0d bg=%b/%b want %b", g, if_l.bg, if_s.bg, want);
         end
         tick(2'b11, 1'b1, 1'b1);
         tick(2'b11, 1'b1, 1'b1);
         drop     = 2'b11;
         drop[ch] = 1'b0;
         tick(drop, 1'b1, 1'b0);
         vectors++;
         if (if_l.end_irq !== want || if_s.end_irq !== want || if_l.last_cnt !== 5'd2) begin
            miscompares++;
            $display("FAIL rr_end%0d irq=%b/%b last=%0d want %b 2", g, if_l.end_irq, if_s.end_irq,
                     if_l.last_cnt, want);
         end
      end
   endtask

   task automatic test_preempt();
      int waited;
      do_reset();
      waited = 0;
      while (if_s.bg === 2'b00 && waited < 8) begin
         tick(2'b11, 1'b1, 1'b1);
         waited++;
      end
      for (int i = 1; i <= 4; i++) begin
         tick(2'b11, 1'b1, 1'b1);
         vectors++;
         if (i < 4) begin
            if (if_s.bg !== 2'b01 || if_s.preempt_irq !== 2'b00) begin
               miscompares++;
               $display("FAIL preempt_burst%0d bg=%b irq=%b want 01 00", i, if_s.bg, if_s.preempt_irq);
            end
         end else if (if_s.preempt_irq !== 2'b01 || if_s.last_cnt !== 3'd4 || if_s.bg !== 2'b00 ||
                      if_s.end_irq !== 2'b00) begin
            miscompares++;
            $display("FAIL preempt_pulse irq=%b last=%0d bg=%b end=%b want 01 4 00 00",
                     if_s.preempt_irq, if_s.last_cnt, if_s.bg, if_s.end_irq);
         end
      end
      waited = 0;
      while (if_s.bg === 2'b00 && waited < 8) begin
         tick(2'b11, 1'b1, 1'b1);
         waited++;
      end
      vectors++;
      if (if_s.bg !== 2'b10) begin
         miscompares++;
         $display("FAIL preempt_next bg=%b want 10", if_s.bg);
      end
   endtask

   task automatic test_withdraw();
      do_reset();
      tick(2'b10, 1'b0, 1'b0);
      vectors++;
      if (if_l.cpu_hold !== 1'b1 || if_l.grant_ch !== 1'b1) begin
         miscompares++;
         $display("FAIL withdraw_wait hold=%b ch=%b want 1 1", if_l.cpu_hold, if_l.grant_ch);
      end
      tick(2'b00, 1'b0, 1'b0);
      vectors++;
      if (if_l.cpu_hold !== 1'b0 || if_l.bg !== 2'b00 || if_l.end_irq !== 2'b00 || if_l.preempt_irq !== 2'b00) begin
         miscompares++;
         $display("FAIL withdraw_idle hold=%b bg=%b end=%b pre=%b want all 0",
                  if_l.cpu_hold, if_l.bg, if_l.end_irq, if_l.preempt_irq);
      end
      tick(2'b00, 1'b1, 1'b0);
      vectors++;
      if (if_l.bg !== 2'b00 || if_l.cpu_hold !== 1'b0) begin
         miscompares++;
         $display("FAIL withdraw_stay bg=%b hold=%b want 00 0", if_l.bg, if_l.cpu_hold);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      tick(2'b01, 1'b1, 1'b0);
      tick(2'b01, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) tick(2'b01, 1'b1, 1'b1);
      tick(2'b00, 1'b1, 1'b1);
      vectors++;
      if (if_s.end_irq !== 2'b01 || if_s.preempt_irq !== 2'b00 || if_s.last_cnt !== 3'd4) begin
         miscompares++;
         $display("FAIL simul_end end=%b pre=%b last=%0d want 01 00 4",
                  if_s.end_irq, if_s.preempt_irq, if_s.last_cnt);
      end
      vectors++;
      if (if_l.end_irq !== 2'b01 || if_l.last_cnt !== 5'd4) begin
         miscompares++;
         $display("FAIL simul_end_l end=%b last=%0d want 01 4", if_l.end_irq, if_l.last_cnt);
      end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      tick(2'b01, 1'b1, 1'b0);
      tick(2'b01, 1'b1, 1'b0);
      tick(2'b01, 1'b1, 1'b1);
      reset = 1'b1;
      tick(2'b01, 1'b1, 1'b1);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (dut_vec(k) !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_mid_grant dut%0d got %h want 0", k, dut_vec(k));
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] b;
      do_reset();
      b = 2'b00;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++)
            if ($urandom_range(0, 7) == 0) b[i] = ~b[i];
         reset = ($urandom_range(0, 249) == 0);
         tick(b, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (dut_vec(k) !== exp_vec(k)) begin
               miscompares++;
               $display("FAIL random_c%0d dut%0d got %h want %h", c, k, dut_vec(k), exp_vec(k));
            end
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      br        = 2'b00;
      mem_idle  = 1'b1;
      xfer_word = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_transfer();
      test_wait_cache();
      test_round_robin();
      test_preempt();
      test_withdraw();
      test_simultaneous();
      test_reset_mid_grant();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
